alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX boundary register of the 5-stage RISC-V pipeline; producer end of the ALU operand/control interface.
- Decodes RV32I instructions into the 3-bit ALU operation code, selects SrcA/SrcB, registers them, and drives the execute-stage ALU one cycle later.
- Supports hazard-unit stall and branch flush, and counts issued instructions.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode stage presents a valid instruction
- in_ready  out  1  stage accepts input this cycle
- instr  in  32  raw instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register-file read port 1
- rs2_data  in  32  register-file read port 2
- stall  in  1  hazard unit hold request
- flush  in  1  branch-mispredict kill
- SrcA  out  32  registered ALU operand A
- SrcB  out  32  registered ALU operand B
- ALUControl  out  3  registered ALU operation code
- rd  out  5  registered destination register
- reg_write  out  1  registered write-back enable
- out_valid  out  1  registered outputs are a live instruction
- illegal  out  1  registered: decoded opcode/funct unsupported
- issue_count  out  CNT_W  number of instructions issued with out_valid=1

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including issue_count. No clock is required for reset to take effect.
- in_ready = !stall (combinational).
- Register update priority on every rising edge: flush > stall > load.
  - flush=1: out_valid<=0, reg_write<=0, illegal<=0. Other fields are don't-care but are held. Applies even when stall=1.
  - stall=1 (no flush): all registers hold.
  - Otherwise: out_valid<=in_valid and the decoded fields load. If in_valid=0, reg_write<=0 and illegal<=0.
- Latency: exactly 1 cycle from acceptance to outputs.
- ALUControl encoding: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SRL=101, SRA=110, SLL=111.
- Decode, by opcode:
  - OP (0110011): SrcA=rs1, SrcB=rs2. SUB when funct7[5]=1 and funct3=000. Shifts use SrcB={27'b0, rs2[4:0]}.
  - OP-IMM (0010011): SrcA=rs1, SrcB=sign-extended imm[11:0]. Shifts use SrcB={27'b0, instr[24:20]}. SRAI when instr[30]=1.
  - LOAD (0000011) / STORE (0100011): ADD, SrcA=rs1, SrcB=I-imm or S-imm respectively. reg_write=1 for loads, 0 for stores.
  - BRANCH (1100011): SUB, SrcA=rs1, SrcB=rs2, reg_write=0.
  - LUI (0110111): ADD, SrcA=0, SrcB={imm[31:12],12'b0}.
  - AUIPC (0010111): ADD, SrcA=pc, SrcB=U-imm.
- Illegal cases, all with illegal=1, reg_write=0, ALUControl=000, out_valid still follows in_valid:
  - SLT/SLTU/SLTI/SLTIU (no ALU code exists);
  - funct7 other than 0000000/0100000 on OP;
  - SUB/SRA funct7 on non-SUB/SRA funct3;
  - any other opcode.
- rd=instr[11:7]. reg_write is also forced 0 when rd=0.
- issue_count increments by 1 on each load edge with in_valid=1 and not flush. It wraps modulo 2^CNT_W and holds during stall.
- Reset asserted mid-stall or mid-flush: outputs clear immediately. First load occurs on the first edge after rst_n rises.

Decomposition:
- Shared package riscv_pkg:
  - ALU opcode localparams (ALU_ADD..ALU_SLL) with the encoding above;
  - opcode constants (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC);
  - immediate-type enum.
- One combinational sub-module, alu_decoder (instr -> ALUControl, operand-select, imm, reg_write, illegal). The top module holds the registers, stall/flush priority and counter.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with in_valid=1 -> all outputs 0 asynchronously; issue_count=0.
- SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3, in_valid=1 -> next cycle SrcA=10, SrcB=3, ALUControl=001, rd=3, reg_write=1, out_valid=1, issue_count=1.
- SRAI x5,x6,4 (0x40435293), rs1=0x80000000 -> SrcB=4, ALUControl=110. SLL with rs2=0x25 -> SrcB=5, ALUControl=111.
- ADDI x1,x0,-1 (0xFFF00093) -> SrcB=0xFFFFFFFF, ALUControl=000. LUI x2,0x12345 -> SrcA=0, SrcB=0x12345000.
- stall=1 for 3 cycles with changing instr -> outputs and issue_count frozen, in_ready=0. Then stall=1 and flush=1 together -> out_valid=0, count unchanged.
- SLT x1,x2,x3 (0x003120B3) -> illegal=1, reg_write=0, out_valid=1. ADD x0,x1,x2 -> reg_write=0, illegal=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: ALU operation codes, major opcodes and
// operand/immediate select types used by the ID/EX issue stage.
package riscv_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SRA = 3'b110;
   localparam logic [2:0] ALU_SLL = 3'b111;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_STD = 7'b0000000;
   localparam logic [6:0] F7_ALT = 7'b0100000;

   typedef enum logic [1:0] {IMM_I, IMM_S, IMM_U, IMM_SH} imm_type_e;
   typedef enum logic [1:0] {SRCA_RS1, SRCA_ZERO, SRCA_PC} srca_sel_e;
   typedef enum logic [1:0] {SRCB_RS2, SRCB_RS2_SHAMT, SRCB_IMM} srcb_sel_e;

   // Takes the instruction without its opcode field; every remaining bit feeds some format.
   function automatic logic [31:0] imm_gen(input logic [31:7] ins, input imm_type_e t);
      logic [31:0] imm;
      case (t)
         IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_U:   imm = {ins[31:12], 12'b0};
         IMM_SH:  imm = {27'b0, ins[24:20]};
         default: imm = 32'b0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decode into ALU operation, operand selects, immediate,
// write-back enable and illegal flag.
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [31:0] instr,
   output logic [2:0]  alu_ctrl,
   output srca_sel_e   srca_sel,
   output srcb_sel_e   srcb_sel,
   output logic [31:0] imm,
   output logic        reg_write,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       alt;
   logic       std;
   logic       writes;
   imm_type_e  imm_type;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign alt    = (funct7 == F7_ALT);
   assign std    = (funct7 == F7_STD);

   always_comb begin
      alu_ctrl = ALU_ADD;
      srca_sel = SRCA_RS1;
      srcb_sel = SRCB_RS2;
      imm_type = IMM_I;
      writes   = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OPC_OP: begin
            writes = 1'b1;
            if (!(std || alt)) illegal = 1'b1;
            else begin
               case (funct3)
                  3'b000: alu_ctrl = alt ? ALU_SUB : ALU_ADD;
                  3'b001: begin alu_ctrl = ALU_SLL; srcb_sel = SRCB_RS2_SHAMT; illegal = alt; end
                  3'b100: begin alu_ctrl = ALU_XOR; illegal = alt; end
                  3'b101: begin alu_ctrl = alt ? ALU_SRA : ALU_SRL; srcb_sel = SRCB_RS2_SHAMT; end
                  3'b110: begin alu_ctrl = ALU_OR;  illegal = alt; end
                  3'b111: begin alu_ctrl = ALU_AND; illegal = alt; end
                  default: illegal = 1'b1;
               endcase
            end
         end
         OPC_OPIMM: begin
            writes   = 1'b1;
            srcb_sel = SRCB_IMM;
            case (funct3)
               3'b000: alu_ctrl = ALU_ADD;
               3'b001: begin alu_ctrl = ALU_SLL; imm_type = IMM_SH; illegal = !std; end
               3'b100: alu_ctrl = ALU_XOR;
               3'b101: begin
                  alu_ctrl = alt ? ALU_SRA : ALU_SRL;
                  imm_type = IMM_SH;
                  illegal  = !(std || alt);
               end
               3'b110: alu_ctrl = ALU_OR;
               3'b111: alu_ctrl = ALU_AND;
               default: illegal = 1'b1;
            endcase
         end
         OPC_LOAD:   begin writes = 1'b1; srcb_sel = SRCB_IMM; end
         OPC_STORE:  begin srcb_sel = SRCB_IMM; imm_type = IMM_S; end
         OPC_BRANCH: alu_ctrl = ALU_SUB;
         OPC_LUI: begin
            writes = 1'b1; srca_sel = SRCA_ZERO; srcb_sel = SRCB_IMM; imm_type = IMM_U;
         end
         OPC_AUIPC: begin
            writes = 1'b1; srca_sel = SRCA_PC; srcb_sel = SRCB_IMM; imm_type = IMM_U;
         end
         default: illegal = 1'b1;
      endcase
      // Unsupported encodings issue as a harmless non-writing ADD.
      if (illegal) alu_ctrl = ALU_ADD;
   end

   assign imm       = imm_gen(instr[31:7], imm_type);
   assign reg_write = writes && !illegal && (instr[11:7] != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register: decodes the instruction, selects ALU operands and
// registers them with stall/flush control and an issued-instruction counter.
module alu_issue_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  logic             stall,
   input  logic             flush,
   output logic [XLEN-1:0]  SrcA,
   output logic [XLEN-1:0]  SrcB,
   output logic [2:0]       ALUControl,
   output logic [4:0]       rd,
   output logic             reg_write,
   output logic             out_valid,
   output logic             illegal,
   output logic [CNT_W-1:0] issue_count
);

   logic [2:0]      dec_alu;
   srca_sel_e       dec_srca_sel;
   srcb_sel_e       dec_srcb_sel;
   logic [31:0]     dec_imm;
   logic            dec_reg_write;
   logic            dec_illegal;
   logic [XLEN-1:0] srca_next;
   logic [XLEN-1:0] srcb_next;

   alu_decoder u_dec (
      .instr     (instr),
      .alu_ctrl  (dec_alu),
      .srca_sel  (dec_srca_sel),
      .srcb_sel  (dec_srcb_sel),
      .imm       (dec_imm),
      .reg_write (dec_reg_write),
      .illegal   (dec_illegal)
   );

   assign in_ready = !stall;

   always_comb begin
      srca_next = rs1_data;
      case (dec_srca_sel)
         SRCA_ZERO: srca_next = '0;
         SRCA_PC:   srca_next = pc;
         default:   srca_next = rs1_data;
      endcase
   end

   always_comb begin
      srcb_next = rs2_data;
      case (dec_srcb_sel)
         SRCB_RS2_SHAMT: srcb_next = {27'b0, rs2_data[4:0]};
         SRCB_IMM:       srcb_next = dec_imm;
         default:        srcb_next = rs2_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SrcA        <= '0;
         SrcB        <= '0;
         ALUControl  <= '0;
         rd          <= '0;
         reg_write   <= 1'b0;
         out_valid   <= 1'b0;
         illegal     <= 1'b0;
         issue_count <= '0;
      end else if (flush) begin
         // Kill only the control bits; the payload is don't-care and just holds.
         out_valid <= 1'b0;
         reg_write <= 1'b0;
         illegal   <= 1'b0;
      end else if (!stall) begin
         out_valid  <= in_valid;
         SrcA       <= srca_next;
         SrcB       <= srcb_next;
         ALUControl <= dec_alu;
         rd         <= instr[11:7];
         reg_write  <= in_valid && dec_reg_write;
         illegal    <= in_valid && dec_illegal;
         if (in_valid) issue_count <= issue_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed literal cases plus
// randomized traffic compared each cycle against a behavioural model.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        stall;
   logic        flush;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [2:0]  ALUControl;
   logic [4:0]  rd;
   logic        reg_write;
   logic        out_valid;
   logic        illegal;
   logic [31:0] issue_count;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .stall(stall), .flush(flush), .SrcA(SrcA), .SrcB(SrcB),
      .ALUControl(ALUControl), .rd(rd), .reg_write(reg_write),
      .out_valid(out_valid), .illegal(illegal), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   // ALU codes by funct3 for the plain (non-alternate) form: ADD SLL - - XOR SRL OR AND.
   localparam logic [2:0] ALU_BY_F3 [8] = '{3'd0, 3'd7, 3'd0, 3'd0, 3'd4, 3'd5, 3'd3, 3'd2};

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  alu;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
   } exp_t;

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                       input logic [31:0] r1, input logic [31:0] r2);
      exp_t        e;
      logic [6:0]  opc  = ins[6:0];
      logic [2:0]  f3   = ins[14:12];
      logic [6:0]  f7   = ins[31:25];
      logic [31:0] iimm = {{20{ins[31]}}, ins[31:20]};
      logic [31:0] simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      logic [31:0] uimm = {ins[31:12], 12'b0};
      bit shift  = (f3 == 3'd1) || (f3 == 3'd5);
      bit slt    = (f3 == 3'd2) || (f3 == 3'd3);
      bit alt_ok = (f3 == 3'd0) || (f3 == 3'd5);
      bit writes = 1'b1;
      e = '0;
      e.a  = r1;
      e.rd = ins[11:7];
      if (opc == 7'h33) begin
         e.b = shift ? (r2 & 32'h1f) : r2;
         if ((f7 != 7'h00 && f7 != 7'h20) || slt || (f7 == 7'h20 && !alt_ok)) e.ill = 1'b1;
         else if (f7 == 7'h20) e.alu = (f3 == 3'd0) ? 3'd1 : 3'd6;
         else e.alu = ALU_BY_F3[f3];
      end else if (opc == 7'h13) begin
         e.b = shift ? {27'b0, ins[24:20]} : iimm;
         if (slt) e.ill = 1'b1;
         else if (shift && f7 != 7'h00 && !(f3 == 3'd5 && f7 == 7'h20)) e.ill = 1'b1;
         else if (shift && f7 == 7'h20) e.alu = 3'd6;
         else e.alu = ALU_BY_F3[f3];
      end else if (opc == 7'h03) e.b = iimm;
      else if (opc == 7'h23) begin e.b = simm; writes = 1'b0; end
      else if (opc == 7'h63) begin e.b = r2; e.alu = 3'd1; writes = 1'b0; end
      else if (opc == 7'h37) begin e.a = 32'd0; e.b = uimm; end
      else if (opc == 7'h17) begin e.a = p; e.b = uimm; end
      else e.ill = 1'b1;
      if (e.ill) e.alu = 3'd0;
      e.rw = writes && !e.ill && (e.rd != 5'd0);
      return e;
   endfunction

   exp_t        dec_now;
   exp_t        m_e;
   logic        m_valid;
   logic        m_rw;
   logic        m_ill;
   logic [31:0] m_cnt;

   always_comb dec_now = ref_decode(instr, pc, rs1_data, rs2_data);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_e <= '0; m_valid <= 1'b0; m_rw <= 1'b0; m_ill <= 1'b0; m_cnt <= 32'd0;
      end else if (flush) begin
         m_valid <= 1'b0; m_rw <= 1'b0; m_ill <= 1'b0;
      end else if (!stall) begin
         m_e     <= dec_now;
         m_valid <= in_valid;
         m_rw    <= in_valid && dec_now.rw;
         m_ill   <= in_valid && dec_now.ill;
         m_cnt   <= m_cnt + (in_valid ? 32'd1 : 32'd0);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("reg_write", 32'(reg_write), 32'(m_rw));
         chk("illegal", 32'(illegal), 32'(m_ill));
         chk("issue_count", issue_count, m_cnt);
         chk("in_ready", 32'(in_ready), 32'(!stall));
         if (m_valid) begin
            chk("rd", 32'(rd), 32'(m_e.rd));
            chk("ALUControl", 32'(ALUControl), 32'(m_e.alu));
            if (!m_ill) begin
               chk("SrcA", SrcA, m_e.a);
               chk("SrcB", SrcB, m_e.b);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                        input logic v, input logic st, input logic fl);
      instr = i; rs1_data = a; rs2_data = b; in_valid = v; stall = st; flush = fl;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " SrcA"}, SrcA, 32'd0);
      chk({tag, " SrcB"}, SrcB, 32'd0);
      chk({tag, " ctrl"}, {21'd0, ALUControl, rd, reg_write, out_valid, illegal}, 32'd0);
      chk({tag, " issue_count"}, issue_count, 32'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int k = $urandom_range(9);
      int f = $urandom_range(5);
      logic [6:0] f7 = (f < 3) ? 7'h00 : (f < 5) ? 7'h20 : w[31:25];
      case (k)
         0, 1: begin w[6:0] = 7'h33; w[31:25] = f7; end
         2, 3: begin
            w[6:0] = 7'h13;
            if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = f7;
         end
         4: w[6:0] = 7'h03;
         5: w[6:0] = 7'h23;
         6: w[6:0] = 7'h63;
         7: w[6:0] = 7'h37;
         8: w[6:0] = 7'h17;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      rst_n = 1'b0; pc = 32'h100;
      drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      chk_all_zero("reset");
      rst_n = 1'b1; cmp_en = 1'b1;

      drive(32'h402081B3, 32'd10, 32'd3, 1'b1, 1'b0, 1'b0);  // SUB x3,x1,x2
      tick();
      chk("sub SrcA", SrcA, 32'd10);
      chk("sub SrcB", SrcB, 32'd3);
      chk("sub alu", 32'(ALUControl), 32'd1);
      chk("sub rd", 32'(rd), 32'd3);
      chk("sub rw/valid", {30'd0, reg_write, out_valid}, 32'd3);
      chk("sub count", issue_count, 32'd1);

      drive(32'h40435293, 32'h80000000, 32'h0, 1'b1, 1'b0, 1'b0);  // SRAI x5,x6,4
      tick();
      chk("srai SrcB", SrcB, 32'd4);
      chk("srai alu", 32'(ALUControl), 32'd6);

      drive(32'h003110B3, 32'h7, 32'h25, 1'b1, 1'b0, 1'b0);  // SLL x1,x2,x3
      tick();
      chk("sll SrcB", SrcB, 32'd5);
      chk("sll alu", 32'(ALUControl), 32'd7);

      drive(32'hFFF00093, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);  // ADDI x1,x0,-1
      tick();
      chk("addi SrcB", SrcB, 32'hFFFFFFFF);
      chk("addi alu", 32'(ALUControl), 32'd0);

      drive(32'h12345137, 32'h55, 32'h66, 1'b1, 1'b0, 1'b0);  // LUI x2,0x12345
      tick();
      chk("lui SrcA", SrcA, 32'd0);
      chk("lui SrcB", SrcB, 32'h12345000);
      chk("lui count", issue_count, 32'd5);

      for (int i = 0; i < 3; i++) begin
         drive(32'h402081B3 + 32'(i << 7), 32'd99, 32'd98, 1'b1, 1'b1, 1'b0);
         #1 chk("stall in_ready", 32'(in_ready), 32'd0);
         tick();
         chk("stall SrcB", SrcB, 32'h12345000);
         chk("stall count", issue_count, 32'd5);
         chk("stall valid", 32'(out_valid), 32'd1);
      end
      drive(32'h402081B3, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1);
      tick();
      chk("flush valid", 32'(out_valid), 32'd0);
      chk("flush count", issue_count, 32'd5);

      drive(32'h003120B3, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);  // SLT x1,x2,x3
      tick();
      chk("slt flags", {29'd0, illegal, reg_write, out_valid}, 32'b101);
      chk("slt alu", 32'(ALUControl), 32'd0);

      drive(32'h00208033, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);  // ADD x0,x1,x2
      tick();
      chk("add x0 flags", {29'd0, illegal, reg_write, out_valid}, 32'b001);
      chk("add x0 count", issue_count, 32'd7);

      drive(32'hFFF00093, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1);
      #3 rst_n = 1'b0;
      #1 chk_all_zero("async reset");
      tick();
      rst_n = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

      for (int c = 0; c < 3000; c++) begin
         tick();
         pc = $urandom;
         drive(rand_instr(), $urandom, $urandom, ($urandom_range(4) != 0),
               ($urandom_range(4) == 0), ($urandom_range(9) == 0));
      end
      tick();
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
